instruction_decode: RTL and testbench
=====================================

// Module: instruction_decode
// PURPOSE
//  ID stage, directly downstream of fetch. Consumes fetch's IR and FM_PC (PC of that IR).
//  Reads the register file and decodes the MIPS-I subset into control bits.
//  Resolves beq/bne/j/jal/jr in ID and returns jump/branch plus targets to fetch.
//  Detects load-use and branch-operand hazards (stall), squashes the wrong-path slot,
//  and registers everything into the ID/EX pipeline register.
// PARAMETERS
//  NUM_REGS  32  register count (index width 5)
//  NOP_IR    0   encoding treated as a bubble
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  curr_state   in   2   2'b00 IDLE, 2'b01 RUN; any value other than RUN forces bubbles
//  id_ir        in   32  instruction from fetch IR
//  id_pc        in   32  its PC (fetch FM_PC)
//  wb_we        in   1   writeback enable
//  wb_rd        in   5   writeback register
//  wb_data      in   32  writeback data
//  mem_mem_read in   1   MEM-stage instruction is lw
//  mem_rd       in   5   MEM-stage destination
//  jump         out  1   comb: j/jal/jr taken this cycle
//  jump_addr    out  32  {id_pc[31:28], ir[25:0], 2'b00}, or rs value for jr
//  branch       out  1   comb: beq/bne condition true
//  branch_addr  out  32  id_pc + 4 + (sext(imm16) << 2)
//  stall        out  1   comb: fetch must hold PC and IR
//  DE_pc, DE_rs_data, DE_rt_data, DE_imm   out  32 each  registered ID/EX data
//  DE_rs, DE_rt, DE_rd                     out  5 each   DE_rd is 31 for jal, 0 when no write
//  DE_alu_op    out  4   ALU op code (package encoding)
//  DE_alu_src, DE_reg_write, DE_mem_read, DE_mem_write, DE_mem_to_reg, DE_link   out  1 each
// BEHAVIOUR
//  - Reset: all DE_* = 0 (bubble), squash = 0, register file cleared to 0.
//  - Decoded ops: add, sub, and, or, slt, jr, addi, andi, ori, slti, lui, lw, sw, beq, bne, j, jal.
//    Unknown opcode/funct -> bubble, never X.
//  - imm: sign-extended for addi/slti/lw/sw/beq/bne; zero-extended for andi/ori; {imm16, 16'b0} for lui.
//  - Register file: 2 async reads, 1 sync write. r0 reads 0 and ignores writes.
//    Write-first bypass: a read of wb_rd in the wb_we cycle returns wb_data.
//  - Hazards:
//    - Load-use: DE_mem_read && DE_rd != 0 && DE_rd matches a used source.
//    - Branch/jr operand: (DE_reg_write && DE_rd matches) || (mem_mem_read && mem_rd matches), rd != 0.
//    - Either -> stall = 1, jump = branch = 0, bubble into ID/EX.
//  - Redirect: taken jump/branch sets squash for exactly 1 cycle.
//    The next id_ir is turned into a bubble and its jump/branch are suppressed.
//    A stall cycle does not consume squash.
//  - jal: DE_link = 1, DE_rd = 31, DE_pc = id_pc; EX writes id_pc + 4.
//  - Non-RUN curr_state: jump = branch = stall = 0, bubble each cycle, squash cleared.
//  - Latency: decode to DE_* takes 1 cycle; jump/branch/stall are same-cycle combinational.
//  - Reset mid-stall: reset wins. The next cycle shows a bubble with stall = 0.
// STRUCTURE
//  - Shared package/header: opcode and funct constants, ALU_ADD..ALU_LUI codes, IDLE/RUN state codes.
//  - One sub-module, register_file (32x32, write-first bypass).
//    Decode, hazard logic and the ID/EX register stay in this module.
// TESTING
//  - Reset, then RUN with addi $1,$0,5 -> next cycle DE_imm = 5, DE_rd = 1,
//    DE_alu_src = 1, DE_reg_write = 1, stall = 0.
//  - lw $2,0($1) then add $3,$2,$2 -> stall = 1 for 1 cycle, 1 bubble in DE_*,
//    then add issues with DE_rs = DE_rt = 2.
//  - wb_we = 1, wb_rd = 4, wb_data = 32'hDEAD_BEEF with ir reading $4 -> same-cycle DE_rs_data = 32'hDEAD_BEEF.
//  - beq $0,$0,+3 at id_pc = 0x40 -> branch = 1, branch_addr = 0x50;
//    following ir is a bubble with branch = jump = 0.
//  - jal 0x100 at id_pc = 0x20 -> jump = 1, jump_addr = 0x400, DE_rd = 31, DE_link = 1;
//    writing $0 via WB leaves $0 reading 0.
//  - curr_state = IDLE with valid ir -> DE_* bubble, jump = branch = stall = 0;
//    rst during stall -> all DE_* = 0 next cycle.

Source files
------------

// File: rtl/instruction_decode_pkg.sv
// Shared encodings and the control decoder for the MIPS-I ID stage.
// The ID/EX bundle type is also defined here.
package instruction_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_LUI = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } state_e;

  typedef enum logic [1:0] {
    IMM_NONE, IMM_SEXT, IMM_ZEXT, IMM_LUI
  } imm_e;

  typedef enum logic [1:0] {
    RD_NONE, RD_RD, RD_RT, RD_RA
  } rd_e;

  typedef struct packed {
    logic    valid;
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    link;
    logic    use_rs;
    logic    use_rt;
    logic    is_beq;
    logic    is_bne;
    logic    is_j;
    logic    is_jr;
    imm_e    imm_sel;
    rd_e     rd_sel;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        link;
  } id_ex_t;

  // Anything not listed decodes to an all-zero (bubble) control word.
  function automatic ctrl_t decode(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    ctrl_t c;
    c = '0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        c.valid     = 1'b1;
        c.use_rs    = 1'b1;
        c.use_rt    = 1'b1;
        c.reg_write = 1'b1;
        c.rd_sel    = RD_RD;
        unique case (1'b1)
          (fn == FN_ADD): c.alu_op = ALU_ADD;
          (fn == FN_SUB): c.alu_op = ALU_SUB;
          (fn == FN_AND): c.alu_op = ALU_AND;
          (fn == FN_OR):  c.alu_op = ALU_OR;
          (fn == FN_SLT): c.alu_op = ALU_SLT;
          (fn == FN_JR): begin
            c.use_rt    = 1'b0;
            c.reg_write = 1'b0;
            c.rd_sel    = RD_NONE;
            c.is_jr     = 1'b1;
          end
          default: c = '0;
        endcase
      end
      (op == OP_J): begin
        c.valid = 1'b1;
        c.is_j  = 1'b1;
      end
      (op == OP_JAL): begin
        c.valid     = 1'b1;
        c.is_j      = 1'b1;
        c.link      = 1'b1;
        c.reg_write = 1'b1;
        c.rd_sel    = RD_RA;
      end
      (op == OP_BEQ),
      (op == OP_BNE): begin
        c.valid   = 1'b1;
        c.alu_op  = ALU_SUB;
        c.use_rs  = 1'b1;
        c.use_rt  = 1'b1;
        c.is_beq  = (op == OP_BEQ);
        c.is_bne  = (op == OP_BNE);
        c.imm_sel = IMM_SEXT;
      end
      (op == OP_ADDI),
      (op == OP_SLTI),
      (op == OP_ANDI),
      (op == OP_ORI),
      (op == OP_LUI),
      (op == OP_LW): begin
        c.valid     = 1'b1;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.use_rs    = (op != OP_LUI);
        c.rd_sel    = RD_RT;
        c.imm_sel   = IMM_SEXT;
        c.mem_read  = (op == OP_LW);
        c.mem_to_reg = (op == OP_LW);
        unique case (1'b1)
          (op == OP_SLTI): c.alu_op = ALU_SLT;
          (op == OP_ANDI): begin
            c.alu_op  = ALU_AND;
            c.imm_sel = IMM_ZEXT;
          end
          (op == OP_ORI): begin
            c.alu_op  = ALU_OR;
            c.imm_sel = IMM_ZEXT;
          end
          (op == OP_LUI): begin
            c.alu_op  = ALU_LUI;
            c.imm_sel = IMM_LUI;
          end
          default: c.alu_op = ALU_ADD;
        endcase
      end
      (op == OP_SW): begin
        c.valid     = 1'b1;
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.use_rs    = 1'b1;
        c.use_rt    = 1'b1;
        c.imm_sel   = IMM_SEXT;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file: two async reads, one sync write.
// Reads of the register being written this cycle return the new data.
module register_file
  import instruction_decode_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [4:0]  ra_addr_i,
  output logic [31:0] ra_data_o,
  input  logic [4:0]  rb_addr_i,
  output logic [31:0] rb_data_o
);

  logic [31:0] mem_q [NUM_REGS];

  function automatic logic [31:0] rd_port(
    input logic [4:0] a
  );
    if (a == 5'd0)
      return 32'd0;
    else if (we_i && (a == wr_addr_i))
      return wr_data_i;
    else
      return mem_q[a];
  endfunction

  assign ra_data_o = rd_port(ra_addr_i);
  assign rb_data_o = rd_port(rb_addr_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem_q[i] <= '0;
    end else if (we_i && (wr_addr_i != 5'd0)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// MIPS-I ID stage: decode, regfile read, branch/jump resolve,
// hazard stall, wrong-path squash and the ID/EX register.
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] NOP_IR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  curr_state,
  input  logic [31:0] id_ir,
  input  logic [31:0] id_pc,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  output logic        jump,
  output logic [31:0] jump_addr,
  output logic        branch,
  output logic [31:0] branch_addr,
  output logic        stall,
  output logic [31:0] DE_pc,
  output logic [31:0] DE_rs_data,
  output logic [31:0] DE_rt_data,
  output logic [31:0] DE_imm,
  output logic [4:0]  DE_rs,
  output logic [4:0]  DE_rt,
  output logic [4:0]  DE_rd,
  output logic [3:0]  DE_alu_op,
  output logic        DE_alu_src,
  output logic        DE_reg_write,
  output logic        DE_mem_read,
  output logic        DE_mem_write,
  output logic        DE_mem_to_reg,
  output logic        DE_link
);

  logic        run;
  logic        squash_q, squash_d;
  logic [31:0] ir;
  ctrl_t       c;
  logic [4:0]  rs, rt;
  logic [31:0] rs_data, rt_data;
  logic [31:0] imm;
  logic [4:0]  rd_w;
  id_ex_t      de_q, de_d;

  assign run = (curr_state == RUN);
  assign ir  = (run && !squash_q) ? id_ir : NOP_IR;
  assign c   = (ir == NOP_IR) ? '0
             : decode(ir[31:26], ir[5:0]);
  assign rs  = ir[25:21];
  assign rt  = ir[20:16];

  register_file #(
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_we),
    .wr_addr_i (wb_rd),
    .wr_data_i (wb_data),
    .ra_addr_i (rs),
    .ra_data_o (rs_data),
    .rb_addr_i (rt),
    .rb_data_o (rt_data)
  );

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_use, br_haz, br_src;

  assign rs_ex  = (de_q.rd != 5'd0) && (de_q.rd == rs);
  assign rt_ex  = (de_q.rd != 5'd0) && (de_q.rd == rt);
  assign rs_mem = (mem_rd != 5'd0) && (mem_rd == rs);
  assign rt_mem = (mem_rd != 5'd0) && (mem_rd == rt);

  assign load_use = de_q.mem_read &&
    ((c.use_rs && rs_ex) || (c.use_rt && rt_ex));

  // Branches compare in ID, so any in-flight producer blocks them.
  assign br_src = c.is_beq | c.is_bne;
  assign br_haz =
    ((br_src | c.is_jr) &&
     ((de_q.reg_write && rs_ex) ||
      (mem_mem_read && rs_mem))) ||
    (br_src &&
     ((de_q.reg_write && rt_ex) ||
      (mem_mem_read && rt_mem)));

  assign stall = load_use | br_haz;

  assign jump   = !stall && (c.is_j | c.is_jr);
  assign branch = !stall &&
    ((c.is_beq && (rs_data == rt_data)) ||
     (c.is_bne && (rs_data != rt_data)));

  assign jump_addr = c.is_jr ? rs_data
    : {id_pc[31:28], ir[25:0], 2'b00};
  assign branch_addr = id_pc + 32'd4 +
    {{14{ir[15]}}, ir[15:0], 2'b00};

  always_comb begin
    imm = '0;
    unique case (c.imm_sel)
      IMM_SEXT: imm = {{16{ir[15]}}, ir[15:0]};
      IMM_ZEXT: imm = {16'd0, ir[15:0]};
      IMM_LUI:  imm = {ir[15:0], 16'd0};
      default:  imm = '0;
    endcase
  end

  always_comb begin
    rd_w = '0;
    unique case (c.rd_sel)
      RD_RD:   rd_w = ir[15:11];
      RD_RT:   rd_w = rt;
      RD_RA:   rd_w = 5'd31;
      default: rd_w = '0;
    endcase
  end

  // A stall holds the same IR, so it must not burn the squash slot.
  always_comb begin
    squash_d = 1'b0;
    if (run) begin
      if (stall)
        squash_d = squash_q;
      else
        squash_d = jump | branch;
    end
  end

  always_comb begin
    de_d = '0;
    if (c.valid && !stall) begin
      de_d.pc         = id_pc;
      de_d.rs_data    = rs_data;
      de_d.rt_data    = rt_data;
      de_d.imm        = imm;
      de_d.rs         = rs;
      de_d.rt         = rt;
      de_d.rd         = rd_w;
      de_d.alu_op     = c.alu_op;
      de_d.alu_src    = c.alu_src;
      de_d.reg_write  = c.reg_write;
      de_d.mem_read   = c.mem_read;
      de_d.mem_write  = c.mem_write;
      de_d.mem_to_reg = c.mem_to_reg;
      de_d.link       = c.link;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q     <= '0;
      squash_q <= 1'b0;
    end else begin
      de_q     <= de_d;
      squash_q <= squash_d;
    end
  end

  assign DE_pc         = de_q.pc;
  assign DE_rs_data    = de_q.rs_data;
  assign DE_rt_data    = de_q.rt_data;
  assign DE_imm        = de_q.imm;
  assign DE_rs         = de_q.rs;
  assign DE_rt         = de_q.rt;
  assign DE_rd         = de_q.rd;
  assign DE_alu_op     = de_q.alu_op;
  assign DE_alu_src    = de_q.alu_src;
  assign DE_reg_write  = de_q.reg_write;
  assign DE_mem_read   = de_q.mem_read;
  assign DE_mem_write  = de_q.mem_write;
  assign DE_mem_to_reg = de_q.mem_to_reg;
  assign DE_link       = de_q.link;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed vectors,
// expected ID/EX words queued and checked by a monitor.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  curr_state;
  logic [31:0] id_ir, id_pc;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_mem_read;
  logic [4:0]  mem_rd;
  logic        jump, branch, stall;
  logic [31:0] jump_addr, branch_addr;
  logic [31:0] DE_pc, DE_rs_data, DE_rt_data, DE_imm;
  logic [4:0]  DE_rs, DE_rt, DE_rd;
  logic [3:0]  DE_alu_op;
  logic        DE_alu_src, DE_reg_write, DE_mem_read;
  logic        DE_mem_write, DE_mem_to_reg, DE_link;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk(clk), .rst(rst), .curr_state(curr_state),
    .id_ir(id_ir), .id_pc(id_pc),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .jump(jump), .jump_addr(jump_addr),
    .branch(branch), .branch_addr(branch_addr),
    .stall(stall),
    .DE_pc(DE_pc), .DE_rs_data(DE_rs_data),
    .DE_rt_data(DE_rt_data), .DE_imm(DE_imm),
    .DE_rs(DE_rs), .DE_rt(DE_rt), .DE_rd(DE_rd),
    .DE_alu_op(DE_alu_op), .DE_alu_src(DE_alu_src),
    .DE_reg_write(DE_reg_write), .DE_mem_read(DE_mem_read),
    .DE_mem_write(DE_mem_write),
    .DE_mem_to_reg(DE_mem_to_reg), .DE_link(DE_link)
  );

  typedef struct packed {
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  alu;
    logic        src, rw, mr, mw, m2r, lk;
  } de_t;

  de_t act, bub;
  de_t sb[$];
  int  errors = 0;
  int  checks = 0;

  assign act = {DE_pc, DE_rs_data, DE_rt_data, DE_imm,
                DE_rs, DE_rt, DE_rd, DE_alu_op,
                DE_alu_src, DE_reg_write, DE_mem_read,
                DE_mem_write, DE_mem_to_reg, DE_link};

  logic        n_rst, n_wbwe, n_mmr;
  logic [1:0]  n_cs;
  logic [4:0]  n_wbrd, n_mrd;
  logic [31:0] n_wbd;

  function automatic de_t mk(
    input logic [31:0] pc, rsd, rtd, imm,
    input logic [4:0] rs, rt, rd,
    input logic [3:0] alu,
    input logic src, rw, mr, mw, m2r, lk
  );
    return {pc, rsd, rtd, imm, rs, rt, rd, alu,
            src, rw, mr, mw, m2r, lk};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [4:0] rs, rt, rd,
    input logic [5:0] fn
  );
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [5:0] op,
    input logic [4:0] rs, rt,
    input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] a, e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  always @(posedge clk) begin
    de_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL de_word: got %h expected %h",
                 act, e);
      end
    end
  end

  task automatic step(
    input string nm,
    input logic [31:0] ir, pc,
    input de_t e,
    input bit cc,
    input logic j, b, s,
    input bit cja, input logic [31:0] ja,
    input bit cba, input logic [31:0] ba
  );
    @(negedge clk);
    rst = n_rst; curr_state = n_cs;
    wb_we = n_wbwe; wb_rd = n_wbrd; wb_data = n_wbd;
    mem_mem_read = n_mmr; mem_rd = n_mrd;
    id_ir = ir; id_pc = pc;
    #1;
    if (cc) begin
      chk({nm, " jump"}, {31'd0, jump}, {31'd0, j});
      chk({nm, " branch"}, {31'd0, branch}, {31'd0, b});
      chk({nm, " stall"}, {31'd0, stall}, {31'd0, s});
    end
    if (cja) chk({nm, " jump_addr"}, jump_addr, ja);
    if (cba) chk({nm, " branch_addr"}, branch_addr, ba);
    sb.push_back(e);
  endtask

  logic [31:0] addi1, add5, lw2, add3, beq3, jal1;
  logic [31:0] add6, add7, jr4, ori8, lui9, slti10;
  logic [31:0] sw4, bne4, add11;

  initial begin
    bub = '0;
    addi1  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    add5   = enc_r(5'd4, 5'd0, 5'd5, 6'h20);
    lw2    = enc_i(6'h23, 5'd1, 5'd2, 16'd0);
    add3   = enc_r(5'd2, 5'd2, 5'd3, 6'h20);
    beq3   = enc_i(6'h04, 5'd0, 5'd0, 16'd3);
    jal1   = {6'h03, 26'h100};
    add6   = enc_r(5'd0, 5'd0, 5'd6, 6'h20);
    add7   = enc_r(5'd0, 5'd4, 5'd7, 6'h20);
    jr4    = enc_r(5'd4, 5'd0, 5'd0, 6'h08);
    ori8   = enc_i(6'h0D, 5'd4, 5'd8, 16'hF0F0);
    lui9   = enc_i(6'h0F, 5'd0, 5'd9, 16'h1234);
    slti10 = enc_i(6'h0A, 5'd1, 5'd10, 16'hFFFF);
    sw4    = enc_i(6'h2B, 5'd0, 5'd4, 16'd8);
    bne4   = enc_i(6'h05, 5'd4, 5'd0, 16'hFFFE);
    add11  = enc_r(5'd4, 5'd0, 5'd11, 6'h20);

    rst = 1'b1; curr_state = 2'b00;
    id_ir = '0; id_pc = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    mem_mem_read = 1'b0; mem_rd = '0;
    n_rst = 1'b1; n_cs = 2'b00; n_wbwe = 1'b0;
    n_wbrd = '0; n_wbd = '0; n_mmr = 1'b0; n_mrd = '0;

    step("rst0", 32'h0, 32'h0, bub, 0, 0,0,0, 0,0, 0,0);
    step("rst1", 32'h0, 32'h0, bub, 0, 0,0,0, 0,0, 0,0);

    n_rst = 1'b0; n_cs = 2'b01;
    step("addi", addi1, 32'h00,
      mk(32'h00, 0, 0, 5, 0, 1, 1, 0, 1,1,0,0,0,0),
      1, 0,0,0, 0,0, 0,0);
    n_wbwe = 1'b1; n_wbrd = 5'd4; n_wbd = 32'hDEAD_BEEF;
    step("bypass", add5, 32'h04,
      mk(32'h04, 32'hDEAD_BEEF, 0, 0, 4, 0, 5, 0,
         0,1,0,0,0,0),
      1, 0,0,0, 0,0, 0,0);
    n_wbwe = 1'b0;
    step("lw", lw2, 32'h08,
      mk(32'h08, 0, 0, 0, 1, 2, 2, 0, 1,1,1,0,1,0),
      1, 0,0,0, 0,0, 0,0);
    step("lu_stall", add3, 32'h0C, bub,
      1, 0,0,1, 0,0, 0,0);
    step("lu_issue", add3, 32'h0C,
      mk(32'h0C, 0, 0, 0, 2, 2, 3, 0, 0,1,0,0,0,0),
      1, 0,0,0, 0,0, 0,0);
    step("beq", beq3, 32'h40,
      mk(32'h40, 0, 0, 3, 0, 0, 0, 1, 0,0,0,0,0,0),
      1, 0,1,0, 0,0, 1,32'h50);
    step("beq_sq", jal1, 32'h44, bub,
      1, 0,0,0, 0,0, 0,0);
    n_wbwe = 1'b1; n_wbrd = 5'd0; n_wbd = 32'hFFFF_FFFF;
    step("jal", jal1, 32'h20,
      mk(32'h20, 0, 0, 0, 0, 0, 31, 0, 0,1,0,0,0,1),
      1, 1,0,0, 1,32'h400, 0,0);
    n_wbwe = 1'b0;
    step("jal_sq", add6, 32'h24, bub,
      1, 0,0,0, 0,0, 0,0);
    step("r0_read", add7, 32'h50,
      mk(32'h50, 0, 32'hDEAD_BEEF, 0, 0, 4, 7, 0,
         0,1,0,0,0,0),
      1, 0,0,0, 0,0, 0,0);
    n_mmr = 1'b1; n_mrd = 5'd4;
    step("jr_stall", jr4, 32'h54, bub,
      1, 0,0,1, 0,0, 0,0);
    n_mmr = 1'b0; n_mrd = 5'd0;
    step("jr", jr4, 32'h54,
      mk(32'h54, 32'hDEAD_BEEF, 0, 0, 4, 0, 0, 0,
         0,0,0,0,0,0),
      1, 1,0,0, 1,32'hDEAD_BEEF, 0,0);
    step("jr_sq", ori8, 32'h58, bub,
      1, 0,0,0, 0,0, 0,0);
    step("ori", ori8, 32'h60,
      mk(32'h60, 32'hDEAD_BEEF, 0, 32'h0000_F0F0,
         4, 8, 8, 3, 1,1,0,0,0,0),
      1, 0,0,0, 0,0, 0,0);
    step("lui", lui9, 32'h64,
      mk(32'h64, 0, 0, 32'h1234_0000, 0, 9, 9, 5,
         1,1,0,0,0,0),
      1, 0,0,0, 0,0, 0,0);
    step("slti", slti10, 32'h68,
      mk(32'h68, 0, 0, 32'hFFFF_FFFF, 1, 10, 10, 4,
         1,1,0,0,0,0),
      1, 0,0,0, 0,0, 0,0);
    step("sw", sw4, 32'h6C,
      mk(32'h6C, 0, 32'hDEAD_BEEF, 8, 0, 4, 0, 0,
         1,0,0,1,0,0),
      1, 0,0,0, 0,0, 0,0);
    step("unknown", 32'hFC00_0000, 32'h70, bub,
      1, 0,0,0, 0,0, 0,0);
    step("bne", bne4, 32'h74,
      mk(32'h74, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFE,
         4, 0, 0, 1, 0,0,0,0,0,0),
      1, 0,1,0, 0,0, 1,32'h70);
    n_cs = 2'b00;
    step("idle_addi", addi1, 32'h78, bub,
      1, 0,0,0, 0,0, 0,0);
    step("idle_beq", beq3, 32'h40, bub,
      1, 0,0,0, 0,0, 0,0);
    n_cs = 2'b01;
    step("lw2", lw2, 32'h80,
      mk(32'h80, 0, 0, 0, 1, 2, 2, 0, 1,1,1,0,1,0),
      1, 0,0,0, 0,0, 0,0);
    n_rst = 1'b1;
    step("rst_stall", add3, 32'h84, bub,
      0, 0,0,0, 0,0, 0,0);
    n_rst = 1'b0;
    step("post_rst", add3, 32'h84,
      mk(32'h84, 0, 0, 0, 2, 2, 3, 0, 0,1,0,0,0,0),
      1, 0,0,0, 0,0, 0,0);
    step("rf_cleared", add11, 32'h88,
      mk(32'h88, 0, 0, 0, 4, 0, 11, 0, 0,1,0,0,0,0),
      1, 0,0,0, 0,0, 0,0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
